// File: rtl/data_mem_responder.sv
// data_mem_responder: word data store answering one CPU read/write per mem_en assertion after programmable wait states
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;
    state_t          state, nxt;
    logic [3:0]      cnt;
    logic            wen_q;
    logic [31:0]     addr_q, wdata_q;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            accept, wen_s, bad;
    logic [31:0]     addr_s, off;
    logic [AW-1:0]   idx;
    // next state; HOLD ensures a single access per mem_en assertion
    always_comb begin
        nxt    = state;
        accept = 1'b0;
        case (state)
            IDLE: if (mem_en) begin
                accept = 1'b1;
                nxt    = (WAIT_CYCLES == 0) ? RESP : BUSY;
            end
            BUSY:    nxt = (cnt == 4'd1) ? RESP : BUSY;
            RESP:    nxt = mem_en ? HOLD : IDLE;
            HOLD:    nxt = mem_en ? HOLD : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // decode the request being served; with zero wait states the live inputs are the request
    always_comb begin
        wen_s  = accept ? mem_wen : wen_q;
        addr_s = accept ? addr : addr_q;
        off    = addr_s - BASE_ADDR;
        bad    = (addr_s[1:0] != 2'b00) || (off >= LIMIT);
        idx    = off[AW+1:2];
    end
    // control state, request latch and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= nxt;
            ready <= (nxt == RESP);
            err   <= (nxt == RESP) && bad;
            busy  <= (nxt == BUSY) || (nxt == RESP);
            if (accept) begin
                wen_q   <= mem_wen;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (nxt == RESP) rdata <= bad ? '0 : (wen_s ? rdata : mem[idx]);
        end
    end
    // store is not reset; writes commit on the edge leaving RESP, so a reset before then drops them
    always_ff @(posedge clk) begin
        if (state == RESP && wen_q && !err) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responder configurations checked each cycle against a timeline model
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        en [2];
    logic        wen [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdo [2];
    logic        rdy [2];
    logic        erro [2];
    logic        bsy [2];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .reset(reset), .mem_en(en[0]), .mem_wen(wen[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdo[0]), .ready(rdy[0]), .err(erro[0]), .busy(bsy[0]));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h1000)) u1 (
        .clk(clk), .reset(reset), .mem_en(en[1]), .mem_wen(wen[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdo[1]), .ready(rdy[1]), .err(erro[1]), .busy(bsy[1]));

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] base(input int i);
        return (i == 0) ? 32'h0 : 32'h1000;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // model: request timeline per instance (accept, W wait cycles, response, drop wait)
    logic [31:0] mm [2][256];
    bit          kn [2][256];
    bit          act [2], rsp [2], hld [2], wp [2];
    int          left [2];
    logic        lw [2];
    logic [31:0] la [2], ld [2];
    logic [7:0]  li [2];
    bit          e_rdy [2], e_err [2], e_bsy [2], e_rk [2];
    logic [31:0] e_rd [2];
    logic [31:0] off;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i] = 0; rsp[i] = 0; hld[i] = 0; wp[i] = 0;
                e_rdy[i] = 0; e_err[i] = 0; e_bsy[i] = 0; e_rd[i] = 0; e_rk[i] = 1;
            end else begin
                e_rdy[i] = 0;
                e_err[i] = 0;
                if (wp[i]) begin
                    mm[i][li[i]] = ld[i];
                    kn[i][li[i]] = 1;
                    wp[i] = 0;
                end
                if (rsp[i]) begin
                    rsp[i] = 0;
                    hld[i] = en[i];
                end else if (hld[i]) begin
                    hld[i] = en[i];
                end else if (!act[i] && en[i]) begin
                    act[i] = 1; lw[i] = wen[i]; la[i] = addr[i]; ld[i] = wdata[i]; left[i] = wc(i);
                end
                if (act[i] && left[i] == 0) begin
                    act[i] = 0;
                    rsp[i] = 1;
                    e_rdy[i] = 1;
                    off = la[i] - base(i);
                    e_err[i] = (la[i][1:0] != 2'b00) || (off >= 32'd1024);
                    li[i] = off[9:2];
                    if (e_err[i]) begin
                        e_rd[i] = 0;
                        e_rk[i] = 1;
                    end else if (lw[i]) begin
                        wp[i] = 1;
                    end else begin
                        e_rd[i] = mm[i][li[i]];
                        e_rk[i] = kn[i][li[i]];
                    end
                end else if (act[i]) begin
                    left[i]--;
                end
                e_bsy[i] = act[i] || rsp[i];
            end
        end
    end

    // compare every cycle, just after the edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d ready", i), 32'(rdy[i]), 32'(e_rdy[i]));
            chk($sformatf("u%0d err", i), 32'(erro[i]), 32'(e_err[i]));
            chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(e_bsy[i]));
            if (e_rk[i]) chk($sformatf("u%0d rdata", i), rdo[i], e_rd[i]);
        end
    end

    task automatic req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int extra, output logic [31:0] rd, output bit e, output int lat,
                       output int pulses);
        @(negedge clk);
        en[i] = 1; wen[i] = w; addr[i] = a; wdata[i] = d;
        lat = 0;
        pulses = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rdy[i] && lat < 40);
        if (!rdy[i]) chk($sformatf("u%0d ready timeout", i), 32'(rdy[i]), 32'd1);
        rd = rdo[i];
        e = erro[i];
        repeat (extra) begin
            @(posedge clk);
            #1;
            if (rdy[i]) pulses++;
        end
        @(negedge clk);
        en[i] = 0; wen[i] = 1'($urandom); addr[i] = $urandom;
    endtask

    logic [31:0] rd;
    bit          e;
    int          lat, pulses;

    initial begin
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; wen[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(rdy[0]), 32'd0);
        chk("reset busy", 32'(bsy[0]), 32'd0);
        chk("reset rdata", rdo[0], 32'd0);
        reset = 0;
        req(0, 1, 32'h10, 32'hDEADBEEF, 0, rd, e, lat, pulses);
        chk("t1 latency", lat, 32'd3);
        chk("t1 err", 32'(e), 32'd0);
        req(0, 0, 32'h10, 32'h0, 0, rd, e, lat, pulses);
        chk("t2 latency", lat, 32'd3);
        chk("t2 rdata", rd, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;
        chk("t2 rdata held", rdo[0], 32'hDEADBEEF);
        req(0, 0, 32'h10, 32'h0, 4, rd, e, lat, pulses);
        chk("t3 extra pulses", pulses, 32'd0);
        req(0, 1, 32'h3FC, 32'h55AA, 0, rd, e, lat, pulses);
        req(0, 0, 32'h12, 32'h0, 0, rd, e, lat, pulses);
        chk("t4 misaligned err", 32'(e), 32'd1);
        chk("t4 misaligned rdata", rd, 32'd0);
        req(0, 1, 32'h400, 32'hBAD, 0, rd, e, lat, pulses);
        chk("t4 range err", 32'(e), 32'd1);
        req(0, 0, 32'h3FC, 32'h0, 0, rd, e, lat, pulses);
        chk("t4 3fc err", 32'(e), 32'd0);
        chk("t4 3fc rdata", rd, 32'h55AA);
        req(0, 1, 32'h20, 32'hCAFE, 0, rd, e, lat, pulses);
        @(negedge clk);
        en[0] = 1; wen[0] = 1; addr[0] = 32'h20; wdata[0] = 32'h1234;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5 busy before reset", 32'(bsy[0]), 32'd1);
        #1;
        reset = 1;
        #1;
        chk("t5 ready in reset", 32'(rdy[0]), 32'd0);
        chk("t5 busy in reset", 32'(bsy[0]), 32'd0);
        chk("t5 rdata in reset", rdo[0], 32'd0);
        en[0] = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        req(0, 0, 32'h20, 32'h0, 0, rd, e, lat, pulses);
        chk("t5 prior contents", rd, 32'hCAFE);
        req(1, 1, 32'h1004, 32'd7, 0, rd, e, lat, pulses);
        chk("t6 write latency", lat, 32'd1);
        req(1, 0, 32'h1004, 32'h0, 0, rd, e, lat, pulses);
        chk("t6 read latency", lat, 32'd1);
        chk("t6 rdata", rd, 32'd7);
        req(1, 0, 32'h0FFC, 32'h0, 0, rd, e, lat, pulses);
        chk("t6 wrapped err", 32'(e), 32'd1);
        for (int n = 0; n < 200; n++) begin
            int i, k;
            logic [31:0] a;
            i = $urandom_range(0, 1);
            k = $urandom_range(0, 9);
            if (k < 7) a = base(i) + 32'(4 * $urandom_range(0, 15));
            else if (k == 7) a = base(i) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (k == 8) a = base(i) + 32'd1024 + 32'(4 * $urandom_range(0, 63));
            else a = $urandom & 32'hFFFF_FFFC;
            req(i, 1'($urandom), a, $urandom, $urandom_range(0, 3), rd, e, lat, pulses);
            chk($sformatf("u%0d rand latency", i), lat, 32'(wc(i) + 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
